mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/aqua_pkg.sv | 38 +++
 rtl/arb_watchdog.sv | 36 +++
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/aqua_pkg.sv
// Shared types for the memory-port arbiter: FSM states and the latched request record.
package aqua_pkg;

  localparam int unsigned AQUA_ADDR_W = 32;
  localparam int unsigned AQUA_DATA_W = 32;
  localparam int unsigned AQUA_STRB_W = AQUA_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                   we;
    logic [AQUA_ADDR_W-1:0] addr;
    logic [AQUA_DATA_W-1:0] wdata;
    logic [AQUA_STRB_W-1:0] strb;
    logic [4:0]             rd;
  } mem_req_t;

  function automatic mem_req_t make_req(
    input logic                   we,
    input logic [AQUA_ADDR_W-1:0] addr,
    input logic [AQUA_DATA_W-1:0] wdata,
    input logic [AQUA_STRB_W-1:0] strb,
    input logic [4:0]             rd
  );
    mem_req_t r;
    r.we    = we;
    r.addr  = addr;
    r.wdata = wdata;
    r.strb  = strb;
    r.rd    = rd;
    return r;
  endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Ack watchdog: counts serving cycles without ack and flags a timeout on the
// TIMEOUT_CYCLES-th one. Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_ack,
  output logic o_timeout
);
  import aqua_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An ack in the terminal cycle wins over the timeout.
  assign o_timeout = i_active && !i_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!i_active || i_ack || o_timeout) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-lane to single-port memory arbiter; lane 0 always served first.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready; latches both lanes when either is valid
// SERVE0 | driving slot 0 on the memory port until ack/timeout
// SERVE1 | driving slot 1 on the memory port until ack/timeout
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid_0,
  input  logic                i_req_we_0,
  input  logic [ADDR_W-1:0]   i_req_addr_0,
  input  logic [DATA_W-1:0]   i_req_wdata_0,
  input  logic [DATA_W/8-1:0] i_req_strb_0,
  input  logic [4:0]          i_req_rd_0,
  input  logic                i_req_valid_1,
  input  logic                i_req_we_1,
  input  logic [ADDR_W-1:0]   i_req_addr_1,
  input  logic [DATA_W-1:0]   i_req_wdata_1,
  input  logic [DATA_W/8-1:0] i_req_strb_1,
  input  logic [4:0]          i_req_rd_1,
  output logic                o_arb_ready,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_strb,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_rsp_valid,
  output logic                o_rsp_lane,
  output logic [4:0]          o_rsp_rd,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err
);
  import aqua_pkg::*;

  arb_state_e state_q, state_d;
  logic       pend0_q, pend0_d, pend1_q, pend1_d;
  mem_req_t   slot0_q, slot0_d, slot1_q, slot1_d;
  mem_req_t   cur;
  logic       serve1;
  logic       mem_req;
  logic       tmo;
  logic       done;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_lane_q, rsp_lane_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign serve1  = (state_q == SERVE1);
  assign cur     = serve1 ? slot1_q : slot0_q;
  // Only a pending slot may reach the port, even if the state were to disagree.
  assign mem_req = ((state_q == SERVE0) && pend0_q) || (serve1 && pend1_q);
  assign done    = mem_req && (i_mem_ack || tmo);

`ifdef MEM_ARB_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_active  (mem_req),
    .i_ack     (i_mem_ack),
    .o_timeout (tmo)
  );

  always_comb begin
    rsp_err_d = 1'b0;
    if (done) begin
      rsp_err_d = !i_mem_ack;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign o_rsp_err = rsp_err_q;
`else
  assign tmo       = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pend0_d     = pend0_q;
    pend1_d     = pend1_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    rsp_valid_d = 1'b0;
    rsp_lane_d  = 1'b0;
    rsp_rd_d    = '0;
    rsp_rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (i_req_valid_0 || i_req_valid_1) begin
          slot0_d = make_req(i_req_we_0, i_req_addr_0, i_req_wdata_0, i_req_strb_0, i_req_rd_0);
          slot1_d = make_req(i_req_we_1, i_req_addr_1, i_req_wdata_1, i_req_strb_1, i_req_rd_1);
          pend0_d = i_req_valid_0;
          pend1_d = i_req_valid_1;
          state_d = i_req_valid_0 ? SERVE0 : SERVE1;
        end
      end
      SERVE0, SERVE1: begin
        if (done) begin
          rsp_valid_d = 1'b1;
          rsp_lane_d  = serve1;
          rsp_rd_d    = cur.rd;
          // Stores and timed-out accesses return zero data.
          rsp_rdata_d = (cur.we || !i_mem_ack) ? '0 : i_mem_rdata;
          if (serve1) begin
            pend1_d = 1'b0;
            state_d = IDLE;
          end else begin
            pend0_d = 1'b0;
            state_d = pend1_q ? SERVE1 : IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend0_d = 1'b0;
        pend1_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_lane_q  <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lane_q  <= rsp_lane_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Slot payloads are qualified by the pending flags and need no reset.
  always_ff @(posedge i_clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign o_arb_ready = (state_q == IDLE);
  assign o_mem_req   = mem_req;
  assign o_mem_we    = cur.we;
  assign o_mem_addr  = cur.addr[ADDR_W-1:0];
  assign o_mem_wdata = cur.wdata[DATA_W-1:0];
  assign o_mem_strb  = cur.strb[DATA_W/8-1:0];
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_lane  = rsp_lane_q;
  assign o_rsp_rd    = rsp_rd_q;
  assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; the timeout scenario runs when
// MEM_ARB_TIMEOUT_EN is defined, otherwise an indefinite-wait scenario runs.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, we0, v1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  strb0, strb1;
  logic [4:0]  rd0, rd1;
  logic        arb_ready, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_strb;
  logic        rsp_valid, rsp_lane, rsp_err;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cnt = 0;

  typedef struct packed {
    logic        lane;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid_0(v0), .i_req_we_0(we0), .i_req_addr_0(addr0),
    .i_req_wdata_0(wdata0), .i_req_strb_0(strb0), .i_req_rd_0(rd0),
    .i_req_valid_1(v1), .i_req_we_1(we1), .i_req_addr_1(addr1),
    .i_req_wdata_1(wdata1), .i_req_strb_1(strb1), .i_req_rd_1(rd1),
    .o_arb_ready(arb_ready), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_strb(mem_strb),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_rsp_valid(rsp_valid), .o_rsp_lane(rsp_lane), .o_rsp_rd(rsp_rd),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && !arb_ready) busy_cnt++;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got lane %0d rd %0d, required no response", rsp_lane, rsp_rd);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_lane", 64'(rsp_lane), 64'(e.lane));
        chk("rsp_rd", 64'(rsp_rd), 64'(e.rd));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; strb0 = 0; rd0 = 0;
    v1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; strb1 = 0; rd1 = 0;
  endtask

  task automatic set_lane0(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic [4:0] rd);
    v0 = 1; we0 = we; addr0 = a; wdata0 = wd; strb0 = s; rd0 = rd;
  endtask

  task automatic set_lane1(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic [4:0] rd);
    v1 = 1; we1 = we; addr1 = a; wdata1 = wd; strb1 = s; rd1 = rd;
  endtask

  // Memory side: checks the port is held for waits+1 cycles, acking in the last one.
  task automatic serve(input string tag, input logic [31:0] a, input logic we,
                       input logic [3:0] s, input logic [31:0] wd, input int waits,
                       input logic [31:0] rdata);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_req"}, 64'(mem_req), 64'd1);
      chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
      chk({tag, "_we"}, 64'(mem_we), 64'(we));
      chk({tag, "_strb"}, 64'(mem_strb), 64'(s));
      chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wd));
      chk({tag, "_ready"}, 64'(arb_ready), 64'd0);
      if (i == waits) begin
        mem_ack = 1; mem_rdata = rdata;
      end
      tick();
    end
    mem_ack = 0; mem_rdata = 0;
  endtask

  initial begin
    int busy_start;
    rst = 1; mem_ack = 0; mem_rdata = 0;
    idle_inputs();
    repeat (3) tick();
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    rst = 0;
    chk("ready_after_reset", 64'(arb_ready), 64'd1);

    // Lone lane-0 load, acked in the first serve cycle.
    set_lane0(0, 32'h100, 32'h0, 4'hF, 5'd5);
    exp_q.push_back('{lane: 1'b0, rd: 5'd5, rdata: 32'hDEADBEEF, err: 1'b0});
    tick();
    idle_inputs();
    serve("t1", 32'h100, 0, 4'hF, 32'h0, 0, 32'hDEADBEEF);
    chk("t1_rsp_latency", 64'(rsp_valid), 64'd1);
    chk("t1_req_dropped", 64'(mem_req), 64'd0);
    chk("t1_ready", 64'(arb_ready), 64'd1);
    tick();

    // Both lanes, three wait cycles each, with requests presented while busy.
    set_lane0(1, 32'h200, 32'hA5A50001, 4'hF, 5'd3);
    set_lane1(0, 32'h204, 32'h0, 4'hF, 5'd7);
    exp_q.push_back('{lane: 1'b0, rd: 5'd3, rdata: 32'h0, err: 1'b0});
    exp_q.push_back('{lane: 1'b1, rd: 5'd7, rdata: 32'h12345678, err: 1'b0});
    busy_start = busy_cnt;
    tick();
    set_lane0(1, 32'hBAD0, 32'h1111, 4'h1, 5'd30);
    set_lane1(1, 32'hBAD4, 32'h2222, 4'h2, 5'd31);
    serve("t2a", 32'h200, 1, 4'hF, 32'hA5A50001, 3, 32'hFFFFFFFF);
    idle_inputs();
    serve("t2b", 32'h204, 0, 4'hF, 32'h0, 3, 32'h12345678);
    chk("t2_ready_back", 64'(arb_ready), 64'd1);
    chk("t2_req_dropped", 64'(mem_req), 64'd0);
    tick();
    chk("t2_busy_cycles", 64'(busy_cnt - busy_start), 64'd8);

    // Only lane 1: partial-strobe store.
    set_lane1(1, 32'h300, 32'h0000BEEF, 4'b0011, 5'd9);
    exp_q.push_back('{lane: 1'b1, rd: 5'd9, rdata: 32'h0, err: 1'b0});
    tick();
    idle_inputs();
    serve("t3", 32'h300, 1, 4'b0011, 32'h0000BEEF, 1, 32'hCAFE);
    chk("t3_ready", 64'(arb_ready), 64'd1);
    tick();

    // Stray ack while idle.
    mem_ack = 1; mem_rdata = 32'h5555;
    repeat (3) begin
      tick();
      chk("t4_stray_ready", 64'(arb_ready), 64'd1);
      chk("t4_stray_req", 64'(mem_req), 64'd0);
    end
    mem_ack = 0; mem_rdata = 0;
    tick();
    chk("t4_no_rsp", 64'(rsp_valid), 64'd0);

    // Reset during SERVE0 with slot 1 pending.
    set_lane0(0, 32'h600, 32'h0, 4'hF, 5'd11);
    set_lane1(0, 32'h604, 32'h0, 4'hF, 5'd12);
    tick();
    idle_inputs();
    chk("t5_serving", 64'(mem_req), 64'd1);
    chk("t5_addr", 64'(mem_addr), 64'h600);
    rst = 1;
    tick();
    chk("t5_req_dropped", 64'(mem_req), 64'd0);
    chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    rst = 0;
    chk("t5_ready", 64'(arb_ready), 64'd1);
    tick();
    chk("t5_still_idle", 64'(mem_req), 64'd0);
    chk("t5_no_rsp_after", 64'(rsp_valid), 64'd0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Lane 0 never acked: four serve cycles, error response, then lane 1.
    set_lane0(0, 32'h400, 32'h0, 4'hF, 5'd1);
    set_lane1(0, 32'h404, 32'h0, 4'hF, 5'd2);
    exp_q.push_back('{lane: 1'b0, rd: 5'd1, rdata: 32'h0, err: 1'b1});
    exp_q.push_back('{lane: 1'b1, rd: 5'd2, rdata: 32'h000055AA, err: 1'b0});
    tick();
    idle_inputs();
    mem_rdata = 32'h777;
    for (int i = 0; i < 4; i++) begin
      chk("t6_stall_req", 64'(mem_req), 64'd1);
      chk("t6_stall_addr", 64'(mem_addr), 64'h400);
      tick();
    end
    chk("t6_err_pulse", 64'(rsp_valid), 64'd1);
    serve("t6b", 32'h404, 0, 4'hF, 32'h0, 0, 32'h000055AA);
    chk("t6_ready", 64'(arb_ready), 64'd1);
`else
    // No watchdog: a long stall is held until ack.
    set_lane0(0, 32'h500, 32'h0, 4'hF, 5'd4);
    exp_q.push_back('{lane: 1'b0, rd: 5'd4, rdata: 32'h0BADF00D, err: 1'b0});
    tick();
    idle_inputs();
    serve("t6", 32'h500, 0, 4'hF, 32'h0, 10, 32'h0BADF00D);
    chk("t6_rsp", 64'(rsp_valid), 64'd1);
    chk("t6_ready", 64'(arb_ready), 64'd1);
`endif

    repeat (3) tick();
    chk("all_rsps_seen", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
